// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction store: byte width and bench timing.
package instruction_memory_pkg;

  localparam int BYTE_SIZE = 8;

  // Long period so a bench can probe the combinational read many times per cycle.
  localparam int CLK_PERIOD = 100;
  localparam int TICK_DELAY = 1;

endpackage

// File: rtl/instruction_memory.sv
// Byte-addressed instruction store: loader writes one word per strobe cycle at an auto-incrementing pointer,
// fetch reads the word at i_pc with zero latency; writes arriving once the store is full are dropped.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10,
  localparam int POINTER_SIZE      = $clog2(MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES)
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_instruction_write,
  input  logic [POINTER_SIZE-1:0]                   i_pc,
  input  logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]   i_instruction,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]   o_instruction
);

  localparam int TOTAL_BYTES = MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES;
  localparam int OFFSET_BITS = $clog2(WORD_SIZE_IN_BYTES);
  localparam int INDEX_BITS  = POINTER_SIZE - OFFSET_BITS;

  // Bytes are grouped per word; element 0 of a word is the lowest byte address,
  // which is also the most significant byte of the word (big-endian).
  logic [0:WORD_SIZE_IN_BYTES-1][BYTE_SIZE-1:0] mem [MEM_SIZE_IN_WORDS];

  // One extra bit so the pointer can sit at TOTAL_BYTES when full.
  logic [POINTER_SIZE:0]   wp;
  logic [INDEX_BITS-1:0]   wr_index;
  logic [INDEX_BITS-1:0]   rd_index;
  logic                    not_full;
  logic                    rd_in_range;

  assign not_full    = 32'(wp) < TOTAL_BYTES;
  assign wr_index    = wp[POINTER_SIZE-1:OFFSET_BITS];
  assign rd_index    = i_pc[POINTER_SIZE-1:OFFSET_BITS];
  assign rd_in_range = 32'(rd_index) < MEM_SIZE_IN_WORDS;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
        mem[i] <= '0;
      end
      wp <= '0;
    end else if (i_instruction_write && not_full) begin
      mem[wr_index] <= i_instruction;
      wp            <= wp + (POINTER_SIZE + 1)'(WORD_SIZE_IN_BYTES);
    end
  end

  assign o_instruction = rd_in_range ? mem[rd_index] : '0;

endmodule

// File: tb/tb_instruction_memory.sv
// Randomised and directed checks of instruction_memory against a byte-array reference model.
module tb_instruction_memory;
  import instruction_memory_pkg::*;

  localparam int W     = 4;
  localparam int M     = 10;
  localparam int TOTAL = W * M;
  localparam int PS    = $clog2(TOTAL);

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_instruction_write;
  logic [PS-1:0]     i_pc;
  logic [W*8-1:0]    i_instruction;
  logic [W*8-1:0]    o_instruction;

  instruction_memory #(
    .WORD_SIZE_IN_BYTES (W),
    .MEM_SIZE_IN_WORDS  (M)
  ) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_instruction_write (i_instruction_write),
    .i_pc                (i_pc),
    .i_instruction       (i_instruction),
    .o_instruction       (o_instruction)
  );

  always #(CLK_PERIOD / 2) i_clk = ~i_clk;

  byte unsigned ref_mem [TOTAL];
  int           ref_wp;
  int           n_vec;
  int           n_err;

  function automatic logic [31:0] ref_read(input int pc);
    logic [31:0] v;
    int          base;
    v    = '0;
    base = (pc / W) * W;
    if (pc / W >= M) return '0;
    for (int b = 0; b < W; b++) v = (v << 8) | 32'(ref_mem[base + b]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, updating the model from the inputs that edge samples.
  task automatic clock_edge();
    @(posedge i_clk);
    if (i_reset) begin
      for (int i = 0; i < TOTAL; i++) ref_mem[i] = 8'h00;
      ref_wp = 0;
    end else if (i_instruction_write && ref_wp < TOTAL) begin
      for (int b = 0; b < W; b++) ref_mem[ref_wp + b] = 8'(i_instruction >> (8 * (W - 1 - b)));
      ref_wp += W;
    end
    #(TICK_DELAY);
  endtask

  task automatic probe(input string tag, input int pc, input logic [31:0] exp);
    i_pc = PS'(pc);
    #(TICK_DELAY);
    check(tag, o_instruction, exp);
  endtask

  task automatic do_reset();
    i_reset             = 1'b1;
    i_instruction_write = 1'b0;
    clock_edge();
    i_reset = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] data);
    i_instruction       = data;
    i_instruction_write = 1'b1;
    clock_edge();
    i_instruction_write = 1'b0;
  endtask

  initial begin
    n_vec               = 0;
    n_err               = 0;
    ref_wp              = 0;
    i_reset             = 1'b1;
    i_instruction_write = 1'b0;
    i_pc                = '0;
    i_instruction       = '0;
    for (int i = 0; i < TOTAL; i++) ref_mem[i] = 8'h00;

    // Reset held five cycles, sweeping every word each cycle.
    for (int c = 0; c < 5; c++) begin
      clock_edge();
      for (int w = 0; w < M; w++) probe("reset_sweep", w * W, 32'h0);
    end
    i_reset = 1'b0;

    // Single write.
    write_word(32'hDEADBEEF);
    probe("single_w0", 0, 32'hDEADBEEF);
    probe("single_w1", 4, 32'h0);

    // Low address bits ignored on read.
    do_reset();
    write_word(32'h11223344);
    for (int p = 0; p < W; p++) probe("align", p, 32'h11223344);

    // Level-sensitive strobe writes one word per cycle.
    do_reset();
    i_instruction       = 32'hA5A5A5A5;
    i_instruction_write = 1'b1;
    repeat (3) clock_edge();
    i_instruction_write = 1'b0;
    for (int w = 0; w < 3; w++) probe("level", w * W, 32'hA5A5A5A5);
    probe("level_w3", 12, 32'h0);

    // Fill past capacity: words 11 and 12 are dropped.
    do_reset();
    i_instruction_write = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      i_instruction = 32'(k);
      clock_edge();
    end
    i_instruction_write = 1'b0;
    for (int w = 0; w < M; w++) probe("full", w * W, 32'(w + 1));
    clock_edge();
    for (int p = TOTAL; p < (1 << PS); p++) probe("out_of_range", p, 32'h0);
    write_word(32'hFFFF0000);
    probe("full_hold", 36, 32'hA);
    do_reset();
    write_word(32'hF);
    probe("reopen_w0", 0, 32'hF);
    probe("reopen_w1", 4, 32'h0);

    // Same-cycle write and read of the word at the pointer.
    do_reset();
    write_word(32'h1);
    write_word(32'h2);
    i_instruction       = 32'h77;
    i_instruction_write = 1'b1;
    probe("rw_before", 8, 32'h0);
    clock_edge();
    i_instruction_write = 1'b0;
    probe("rw_after", 8, 32'h77);

    // Reset mid-fill, with the strobe still high, aborts the load.
    i_reset             = 1'b1;
    i_instruction_write = 1'b1;
    clock_edge();
    i_reset = 1'b0;
    i_instruction_write = 1'b0;
    probe("abort_w2", 8, 32'h0);
    write_word(32'h55);
    probe("abort_w0", 0, 32'h55);
    probe("abort_w1", 4, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int pc;
      i_reset             = ($urandom_range(0, 39) == 0);
      i_instruction_write = ($urandom_range(0, 2) != 0);
      i_instruction       = $urandom;
      pc                  = $urandom_range(0, (1 << PS) - 1);
      probe("rand_pre", pc, ref_read(pc));
      clock_edge();
      probe("rand_post", pc, ref_read(pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
